bram_ctrl_mp: RTL and testbench

- Parametrised successor of the single-bank fixed-latency BRAM controller in the user-project memory subsystem.
- Accepts one read/write request per cycle from the arbiter and delays it through an in-order pipeline of programmable depth, emulating BRAM latency, before it touches an internal word array.
- Routes read data back to one of NUM_SRC requesters (DMA, CPU cache, prefetch cache, ...) with a one-hot valid and a tag.
- Adds byte write strobes, range checking, a pipeline flush and in-flight accounting.

---
 rtl/bram_ctrl_mp.sv | 132 +++++++++++++
 tb/tb_bram_ctrl_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_ctrl_mp.sv
// bram_ctrl_mp: multi-requester BRAM controller with a programmable-latency in-order
// pipeline, byte strobes, source range check, flush and in-flight accounting.
`default_nettype none

module bram_ctrl_mp #(
  parameter  int ADDR_W  = 13,
  parameter  int DATA_W  = 32,
  parameter  int NUM_SRC = 3,
  parameter  int LATENCY = 10,
  parameter  int TAG_W   = 4,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [STRB_W-1:0]   req_wstrb,
  input  logic [SRC_W-1:0]    req_src,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                flush,
  output logic [NUM_SRC-1:0]  rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                req_err,
  output logic [5:0]          inflight,
  output logic                busy
);

  localparam int NSTG = LATENCY - 1;
  localparam int LAST = NSTG - 1;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic [NSTG-1:0]   r_vld;
  logic [NSTG-1:0]   r_we;
  logic [ADDR_W-1:0] r_addr  [NSTG];
  logic [DATA_W-1:0] r_wdata [NSTG];
  logic [STRB_W-1:0] r_strb  [NSTG];
  logic [SRC_W-1:0]  r_src   [NSTG];
  logic [TAG_W-1:0]  r_tag   [NSTG];

  logic [NUM_SRC-1:0] r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic [TAG_W-1:0]   r_rd_tag;
  logic               r_req_err;
  logic [5:0]         r_inflight;

  logic w_src_ok;
  logic w_acc;
  logic w_last;

  assign w_src_ok = ({1'b0, req_src} < (SRC_W+1)'(NUM_SRC));
  assign w_acc    = req_valid && w_src_ok && !flush;
  // The last-stage entry accesses the array on this edge, so flush does not cancel it.
  assign w_last   = r_vld[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc;
      for (int k = 1; k < NSTG; k++) begin
        r_vld[k] <= r_vld[k-1] & ~flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_we[0]    <= req_we;
    r_addr[0]  <= req_addr;
    r_wdata[0] <= req_wdata;
    r_strb[0]  <= req_wstrb;
    r_src[0]   <= req_src;
    r_tag[0]   <= req_tag;
    for (int k = 1; k < NSTG; k++) begin
      r_we[k]    <= r_we[k-1];
      r_addr[k]  <= r_addr[k-1];
      r_wdata[k] <= r_wdata[k-1];
      r_strb[k]  <= r_strb[k-1];
      r_src[k]   <= r_src[k-1];
      r_tag[k]   <= r_tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_last && r_we[LAST]) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_strb[LAST][b]) begin
          r_mem[r_addr[LAST]][b*8 +: 8] <= r_wdata[LAST][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_rd_tag   <= '0;
      r_req_err  <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_rd_valid <= '0;
      if (w_last && !r_we[LAST]) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          r_rd_valid[i] <= (r_src[LAST] == SRC_W'(i));
        end
        r_rd_data <= r_mem[r_addr[LAST]];
        r_rd_tag  <= r_tag[LAST];
      end
      r_req_err <= req_valid && !w_src_ok;
      if (flush) begin
        r_inflight <= '0;
      end else begin
        r_inflight <= r_inflight + 6'(w_acc) - 6'(w_last);
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_tag   = r_rd_tag;
  assign req_err  = r_req_err;
  assign inflight = r_inflight;
  assign busy     = (r_inflight != 6'd0);

endmodule

`default_nettype wire

// File: tb/tb_bram_ctrl_mp.sv
// tb_bram_ctrl_mp: scoreboard bench for bram_ctrl_mp at default parameters.
`default_nettype none

module tb_bram_ctrl_mp;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, flush;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_src;
  logic [3:0]  req_tag;
  logic [2:0]  rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_tag;
  logic        req_err, busy;
  logic [5:0]  inflight;

  bram_ctrl_mp dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_src(req_src), .req_tag(req_tag), .flush(flush),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .req_err(req_err), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d;
    logic [3:0]  t;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          n_tot = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid !== 3'b000) begin
      if (q.size() == 0) begin
        chk("spurious_rd_valid", 64'(rd_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_valid", 64'(rd_valid), 64'(e.v));
        chk("rd_data", 64'(rd_data), 64'(e.d));
        chk("rd_tag", 64'(rd_tag), 64'(e.t));
        chk("rd_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      chk("missed_rd", 64'(cyc), 64'(q[0].due));
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input logic we, input logic [12:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [1:0] src, input logic [3:0] tg);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_wstrb = st; req_src = src; req_tag = tg;
    if (src < 2'd3 && !flush) begin
      if (we) begin
        logic [31:0] w;
        w = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        mdl[int'(a)] = w;
      end else begin
        exp_t e;
        e.v = 3'b001 << src; e.d = mdl[int'(a)]; e.t = tg; e.due = cyc + LAT;
        q.push_back(e);
      end
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] wd, input logic [3:0] st);
    req(1'b1, a, wd, st, 2'd0, 4'd0);
  endtask

  task automatic rd(input logic [12:0] a, input logic [1:0] src, input logic [3:0] tg);
    req(1'b0, a, 32'h0, 4'h0, src, tg);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_src = '0; req_tag = '0; flush = 1'b0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_tag", 64'(rd_tag), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_err", 64'(req_err), 64'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Write then read one cycle later.
    wr(13'h0010, 32'hDEADBEEF, 4'hF);
    rd(13'h0010, 2'd1, 4'h5);
    idle(14);
    chk("hold_data", 64'(rd_data), 64'hDEADBEEF);
    chk("hold_tag", 64'(rd_tag), 64'h5);

    // Back-to-back reads to all sources.
    wr(13'h0020, 32'hA, 4'hF);
    wr(13'h0021, 32'hB, 4'hF);
    wr(13'h0022, 32'hC, 4'hF);
    idle(12);
    rd(13'h0020, 2'd0, 4'h1);
    rd(13'h0021, 2'd1, 4'h2);
    rd(13'h0022, 2'd2, 4'h3);
    chk("inflight_peak", 64'(inflight), 64'd3);
    chk("busy_peak", 64'(busy), 64'd1);
    idle(12);
    chk("inflight_drained", 64'(inflight), 64'd0);
    chk("busy_drained", 64'(busy), 64'd0);

    // Byte strobes at the top address, including an all-zero strobe no-op.
    wr(13'h1FFF, 32'hFFFFFFFF, 4'hF);
    wr(13'h1FFF, 32'h00000000, 4'b0101);
    wr(13'h1FFF, 32'h12345678, 4'b0000);
    rd(13'h1FFF, 2'd2, 4'h9);
    idle(12);

    // Flush cancels in-flight reads and the request presented with it.
    rd(13'h0020, 2'd0, 4'h1);
    rd(13'h0021, 2'd1, 4'h2);
    rd(13'h0022, 2'd2, 4'h3);
    flush = 1'b1;
    while (q.size() > 0 && q[q.size()-1].due > cyc + 1) void'(q.pop_back());
    rd(13'h0010, 2'd0, 4'h4);
    flush = 1'b0;
    chk("flush_inflight", 64'(inflight), 64'd0);
    rd(13'h0021, 2'd1, 4'h7);
    chk("post_flush_inflight", 64'(inflight), 64'd1);
    idle(12);

    // Out-of-range source.
    rd(13'h0020, 2'd3, 4'h1);
    chk("req_err_pulse", 64'(req_err), 64'd1);
    chk("req_err_inflight", 64'(inflight), 64'd0);
    tick();
    chk("req_err_clear", 64'(req_err), 64'd0);
    idle(12);

    // Reset mid-flight discards the request.
    rd(13'h0020, 2'd0, 4'h6);
    idle(3);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_inflight", 64'(inflight), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(14);

    // Random mixed traffic over a small address window.
    for (int a = 0; a < 8; a++) wr(13'h0100 + 13'(a), $urandom, 4'hF);
    for (int i = 0; i < 60; i++) begin
      logic [12:0] a;
      a = 13'h0100 + 13'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)));
      else rd(a, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 30 && q.size() > 0; i++) tick();
    chk("drain", 64'(q.size()), 64'd0);
    idle(2);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
